// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: widths, ALU opcodes and
// the ID/EX buffer-entry record, plus the immediate sign-extension helper.
// Imported by id_ex_stage and id_ex_fwd_mux.
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int IMM_W  = 6;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;

    // One decoded instruction as held in the ID/EX buffer.
    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm_ext;
        logic              use_imm;
        logic              reg_write;
    } id_ex_entry_t;

    // Replicate the immediate's top bit up to the full datapath width.
    function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB data, else stored value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a match needs reg_write, equal rd and a non-zero address.
module id_ex_fwd_mux
    import mips_pkg::*;
(
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    // Youngest producer wins; r0 is never forwarded since it is hard-wired zero.
    always_comb begin
        fwd_data = reg_data;
        if (exmem_reg_write && (exmem_rd == addr) && (addr != '0)) begin
            fwd_data = exmem_res;
        end else if (memwb_reg_write && (memwb_rd == addr) && (addr != '0)) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX 2-entry buffer feeding the ALU; forwarding enabled by macro ID_EX_FWD_EN.
// Latency: entry pushed into an empty buffer is at the head one edge later.
// Backpressure: in_ready drops when 2 entries are held; flush empties the buffer.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_alu_op,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              in_reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write
);

    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    id_ex_entry_t buf_q [2];
    id_ex_entry_t new_entry;
    id_ex_entry_t head;
    logic         push;
    logic         pop;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = buf_q[rd_ptr];

    // Pack the incoming decode fields; the immediate is widened here, once.
    always_comb begin
        new_entry           = '0;
        new_entry.op        = in_alu_op;
        new_entry.rs        = in_rs_addr;
        new_entry.rt        = in_rt_addr;
        new_entry.rd        = in_rd_addr;
        new_entry.rs_data   = in_rs_data;
        new_entry.rt_data   = in_rt_data;
        new_entry.imm_ext   = sign_ext_imm(in_imm);
        new_entry.use_imm   = in_use_imm;
        new_entry.reg_write = in_reg_write;
    end

    // Circular buffer state; flush resets occupancy but leaves payload untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= new_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ID_EX_FWD_EN
    id_ex_fwd_mux u_fwd_rs (
        .addr            (head.rs),
        .reg_data        (head.rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_res       (exmem_res),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (rs_fwd)
    );

    id_ex_fwd_mux u_fwd_rt (
        .addr            (head.rt),
        .reg_data        (head.rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_res       (exmem_res),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (rt_fwd)
    );
`else
    // Without forwarding the forward ports and source addresses have no consumer.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_res,
                          memwb_reg_write, memwb_rd, memwb_data,
                          head.rs, head.rt};
    assign rs_fwd = head.rs_data;
    assign rt_fwd = head.rt_data;
`endif

    // Drive the ALU from the head entry; an empty buffer presents all zeros.
    always_comb begin
        alu_opcode    = '0;
        alu_a         = '0;
        alu_b         = '0;
        out_rt_data   = '0;
        out_rd        = '0;
        out_reg_write = 1'b0;
        if (out_valid) begin
            alu_opcode    = head.op;
            alu_a         = rs_fwd;
            alu_b         = head.use_imm ? head.imm_ext : rt_fwd;
            out_rt_data   = rt_fwd;
            out_rd        = head.rd;
            out_reg_write = head.reg_write;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random traffic.
// A monitor checks every cycle against a queue-based model of the buffer.
// Build with ID_EX_FWD_EN defined to expect forwarding, undefined to expect none.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_op;
    logic [2:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic [15:0] in_rs_data, in_rt_data;
    logic [5:0]  in_imm;
    logic        in_use_imm, in_reg_write;
    logic        exmem_reg_write;
    logic [2:0]  exmem_rd;
    logic [15:0] exmem_res;
    logic        memwb_reg_write;
    logic [2:0]  memwb_rd;
    logic [15:0] memwb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, out_rt_data;
    logic [2:0]  out_rd;
    logic        out_reg_write;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rs, rt, rd;
        logic [15:0] rs_data, rt_data;
        logic [5:0]  imm;
        logic        use_imm, reg_write;
    } ent_t;

    ent_t model_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rd_addr(in_rd_addr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_reg_write(in_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .out_rt_data(out_rt_data), .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Immediate as a signed number, folded back into 16 bits.
    function automatic logic [15:0] sext(input logic [5:0] imm);
        int v;
        v = int'(imm);
        if (v >= 32) v = v - 64;
        return 16'(v);
    endfunction

    // Value the execute stage should see for a source register right now.
    function automatic logic [15:0] fwd_ref(input logic [2:0] a, input logic [15:0] stored);
`ifdef ID_EX_FWD_EN
        if (a != 3'd0 && exmem_reg_write && exmem_rd == a) return exmem_res;
        if (a != 3'd0 && memwb_reg_write && memwb_rd == a) return memwb_data;
`endif
        return stored;
    endfunction

    // Monitor: compare outputs to the model head, then advance the model.
    initial begin
        ent_t h;
        ent_t cur;
        bit   do_push, do_pop;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) model_q.delete();
            chk("out_valid", 16'(out_valid), 16'(model_q.size() != 0));
            chk("in_ready",  16'(in_ready),  16'(model_q.size() != 2));
            if (model_q.size() != 0) begin
                h = model_q[0];
                chk("alu_opcode", 16'(alu_opcode), 16'(h.op));
                chk("alu_a", alu_a, fwd_ref(h.rs, h.rs_data));
                chk("alu_b", alu_b, h.use_imm ? sext(h.imm) : fwd_ref(h.rt, h.rt_data));
                chk("out_rt_data", out_rt_data, fwd_ref(h.rt, h.rt_data));
                chk("out_rd", 16'(out_rd), 16'(h.rd));
                chk("out_reg_write", 16'(out_reg_write), 16'(h.reg_write));
            end else begin
                chk("idle_outputs", {alu_a | alu_b | out_rt_data},
                    16'h0000);
                chk("idle_ctrl", 16'({alu_opcode, out_rd, out_reg_write}), 16'h0000);
            end
            if (rst !== 1'b1) begin
                if (flush) begin
                    model_q.delete();
                end else begin
                    do_push = in_valid && (model_q.size() < 2);
                    do_pop  = out_ready && (model_q.size() > 0);
                    cur = '{in_alu_op, in_rs_addr, in_rt_addr, in_rd_addr,
                            in_rs_data, in_rt_data, in_imm, in_use_imm, in_reg_write};
                    if (do_pop)  void'(model_q.pop_front());
                    if (do_push) model_q.push_back(cur);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                          input logic [2:0] rd, input logic [15:0] a, input logic [15:0] b,
                          input logic [5:0] imm, input logic ui, input logic rw);
        in_valid = 1'b1;
        in_alu_op = op; in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
        in_rs_data = a; in_rt_data = b; in_imm = imm; in_use_imm = ui; in_reg_write = rw;
    endtask

    task automatic set_fwd(input logic ew, input logic [2:0] er, input logic [15:0] ed,
                           input logic mw, input logic [2:0] mr, input logic [15:0] md);
        exmem_reg_write = ew; exmem_rd = er; exmem_res = ed;
        memwb_reg_write = mw; memwb_rd = mr; memwb_data = md;
    endtask

    initial begin
        logic [15:0] exp_a;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 6'h0, 1'b0, 1'b0);
        in_valid = 1'b0;
        set_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        @(negedge clk);
        chk("reset_in_ready", 16'(in_ready), 16'h1);
        chk("reset_out_valid", 16'(out_valid), 16'h0);
        chk("reset_alu_a", alu_a, 16'h0);
        chk("reset_alu_b", alu_b, 16'h0);
        chk("reset_opcode", 16'(alu_opcode), 16'h0);
        step();
        rst = 1'b0;
        step();

        // add r1,r2 -> r3
        out_ready = 1'b1;
        set_in(3'd0, 3'd1, 3'd2, 3'd3, 16'd5, 16'd7, 6'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_valid", 16'(out_valid), 16'h1);
        chk("add_a", alu_a, 16'd5);
        chk("add_b", alu_b, 16'd7);
        chk("add_rd", 16'(out_rd), 16'd3);
        step();

        // Immediates: negative then positive, back to back
        set_in(3'd1, 3'd1, 3'd2, 3'd4, 16'd9, 16'd9, 6'b111101, 1'b1, 1'b1);
        step();
        set_in(3'd2, 3'd1, 3'd2, 3'd4, 16'd9, 16'd9, 6'b011111, 1'b1, 1'b1);
        @(negedge clk);
        chk("imm_neg", alu_b, 16'hFFFD);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("imm_pos", alu_b, 16'h001F);
        step();

        // Forwarding priority on head rs=2 (stored 5)
        out_ready = 1'b0;
        set_in(3'd0, 3'd2, 3'd5, 3'd6, 16'd5, 16'd8, 6'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        set_fwd(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 16'h00BB);
`ifdef ID_EX_FWD_EN
        exp_a = 16'h00AA;
`else
        exp_a = 16'd5;
`endif
        @(negedge clk);
        chk("fwd_exmem", alu_a, exp_a);
        step();
        exmem_reg_write = 1'b0;
`ifdef ID_EX_FWD_EN
        exp_a = 16'h00BB;
`else
        exp_a = 16'd5;
`endif
        @(negedge clk);
        chk("fwd_memwb", alu_a, exp_a);
        step();
        // Replace head with an rs=r0 instruction while both forwards target r0
        set_fwd(1'b1, 3'd0, 16'h00AA, 1'b1, 3'd0, 16'h00BB);
        out_ready = 1'b1;
        set_in(3'd0, 3'd0, 3'd0, 3'd1, 16'd5, 16'd3, 6'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("fwd_r0", alu_a, 16'd5);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        set_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

        // Three back-to-back pushes into a stalled buffer
        set_in(3'd0, 3'd1, 3'd1, 3'd1, 16'h11, 16'h12, 6'd0, 1'b0, 1'b1);
        step();
        set_in(3'd1, 3'd2, 3'd2, 3'd2, 16'h21, 16'h22, 6'd0, 1'b0, 1'b1);
        step();
        set_in(3'd3, 3'd3, 3'd3, 3'd3, 16'h31, 16'h32, 6'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_in_ready", 16'(in_ready), 16'h0);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("drained_valid", 16'(out_valid), 16'h0);
        step();

        // Flush with a full buffer and an incoming entry
        out_ready = 1'b0;
        set_in(3'd4, 3'd1, 3'd2, 3'd3, 16'h41, 16'h42, 6'd0, 1'b0, 1'b1);
        step();
        set_in(3'd4, 3'd2, 3'd3, 3'd4, 16'h51, 16'h52, 6'd0, 1'b0, 1'b1);
        step();
        set_in(3'd4, 3'd3, 3'd4, 3'd5, 16'h61, 16'h62, 6'd0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 16'(out_valid), 16'h0);
        chk("flush_in_ready", 16'(in_ready), 16'h1);
        step();

        // Random traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 2000; i++) begin
            set_in(3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom),
                   16'($urandom), 16'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            set_fwd(1'($urandom), 3'($urandom), 16'($urandom),
                    1'($urandom), 3'($urandom), 16'($urandom));
            rst = (i == 1000);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute buffer of the 16-bit MIPS pipeline. It accepts decoded instructions from the decode stage over a valid/ready handshake and holds them in a 2-entry buffer. The head entry drives the ALU operand and opcode inputs, with EX/MEM and MEM/WB result forwarding applied to the register operands. Flush discards all buffered instructions on a branch redirect.

## Interface
- DATA_W, 16, operand/result width
- REG_AW, 3, register-address width (8 GPRs, r0 hard-wired zero)
- IMM_W, 6, immediate field width, sign-extended to DATA_W

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  decode entry valid
- in_ready  out  1  buffer can accept an entry
- in_alu_op  in  3  ALU opcode (000 add, 001 sub, 010 sll, 011 srl, 100 sra)
- in_rs_addr, in_rt_addr, in_rd_addr  in  REG_AW each  source/destination registers
- in_rs_data, in_rt_data  in  DATA_W each  register-file read data
- in_imm  in  IMM_W  immediate
- in_use_imm  in  1  B operand is the immediate
- in_reg_write  in  1  instruction writes rd
- exmem_reg_write, exmem_rd, exmem_res  in  1/REG_AW/DATA_W  EX/MEM forward source
- memwb_reg_write, memwb_rd, memwb_data  in  1/REG_AW/DATA_W  MEM/WB forward source
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage consumes head
- alu_opcode  out  3  to ALU opcode
- alu_a, alu_b  out  DATA_W each  to ALU A/B
- out_rt_data  out  DATA_W  forwarded rt value (store data)
- out_rd  out  REG_AW  destination register
- out_reg_write  out  1  write-enable for rd

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- The buffer is a 2-entry circular buffer with 1-bit read/write pointers and a count of 0..2. Pointers wrap 1→0.
- in_ready = (count != 2). It is a pure function of registered count.
- out_valid = (count != 0).
- Simultaneous push and pop keep count unchanged and advance both pointers.
- When count==0, alu_opcode, alu_a, alu_b, out_rt_data, out_rd and out_reg_write are all driven 0.
- Forwarding uses the head entry's rs/rt addresses and the current-cycle forward ports, combinationally:
  - EX/MEM has priority over MEM/WB.
  - A match requires reg_write=1 and rd==addr and addr!=0.
  - Otherwise the stored register-file data is used.
- Operand selection:
  - alu_a = forwarded rs.
  - alu_b = in_use_imm ? sign-extended imm : forwarded rt.
  - out_rt_data is always forwarded rt.
- Immediate: bit IMM_W-1 is replicated into bits DATA_W-1..IMM_W. It is extended at push and stored at DATA_W.
- flush clears count and both pointers at the next edge. A push or pop in the same cycle is ignored, and flush wins.
- The entry payload is not cleared by flush.

## Timing
- Reset (async assert) sets count=0 and pointers=0, and zeroes all payload. Immediately after assertion: in_ready=1, out_valid=0, all datapath outputs 0.
- Latency: an entry pushed at edge N is visible at the head after edge N if the buffer was empty.
- Throughput: 1 entry/cycle sustained with out_ready held high.
- Forwarding path: combinational from the exmem_*/memwb_* ports to alu_a/alu_b/out_rt_data in the same cycle. No registered forwarding.
- Reset asserted mid-operation drops all entries. No partial entry survives.

## Configuration
- ID_EX_FWD_EN defined: forwarding as above.
- ID_EX_FWD_EN undefined: alu_a/alu_b/out_rt_data use the stored register-file data only.
  - The forward ports remain in the port list and are ignored.
  - The forward mux is not instantiated.

## Structure
- Shared package mips_pkg holds:
  - DATA_W and REG_AW.
  - ALU opcode constants ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA.
  - The buffer-entry record (op, rs, rt, rd, rs_data, rt_data, imm_ext, use_imm, reg_write).
- Sub-module id_ex_fwd_mux is combinational. It takes (addr, stored data, both forward sources) and returns the forwarded value.
- id_ex_fwd_mux is instantiated twice (rs, rt) under ID_EX_FWD_EN.

## Test plan
- Reset then idle → in_ready=1, out_valid=0, alu_a=alu_b=0, alu_opcode=000.
- Push add r1,r2→r3 with rs_data=5, rt_data=7, out_ready=1 → next cycle out_valid=1, alu_opcode=000, alu_a=5, alu_b=7, out_rd=3.
- Push with use_imm=1 and imm=6'b111101 → alu_b=16'hFFFD. With imm=6'b011111 → alu_b=16'h001F.
- Forwarding, head rs=2 stored 5:
  - exmem_rd=2, exmem_res=16'h00AA, memwb_rd=2, memwb_data=16'h00BB → alu_a=16'h00AA.
  - EX/MEM reg_write dropped → alu_a=16'h00BB.
  - rs=0 with both forwards targeting r0 → alu_a=stored value.
- out_ready=0, push 3 back-to-back → two accepted, in_ready=0 on the third. Release out_ready → entries pop in order, count reaches 0.
- Buffer holding 2 entries, assert flush with in_valid=1 → next cycle out_valid=0, count=0, in_ready=1, incoming entry dropped.
